// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the response-mux state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } mux_state_e;

endpackage

// File: rtl/ahb_wait_timeout.sv
// Counts consecutive stalled data-phase cycles and flags when the limit
// is reached so the mux can terminate the transfer with an ERROR.
module ahb_wait_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = stall ? cnt_q + 1'b1 : '0;
        expire = stall && (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave-to-master response mux with registered data-phase select.
// Optional wait-state timeout: define AHB_SLAVE_MUX_TIMEOUT_EN.
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int SLAVE_NUM      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [$clog2(SLAVE_NUM)-1:0] MUX_SEL,
    input  logic [1:0]                   HTRANS,
    input  logic [DATA_WIDTH-1:0]        HRDATA_1,
    input  logic [DATA_WIDTH-1:0]        HRDATA_2,
    input  logic [DATA_WIDTH-1:0]        HRDATA_3,
    input  logic [DATA_WIDTH-1:0]        HRDATA_4,
    input  logic                         HREADYOUT_1,
    input  logic                         HREADYOUT_2,
    input  logic                         HREADYOUT_3,
    input  logic                         HREADYOUT_4,
    input  logic                         HRESP_1,
    input  logic                         HRESP_2,
    input  logic                         HRESP_3,
    input  logic                         HRESP_4,
    output logic [DATA_WIDTH-1:0]        HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [$clog2(SLAVE_NUM)-1:0] DATA_SEL
);

    localparam int SEL_W = $clog2(SLAVE_NUM);
    // One bit per physical port; unpopulated indices read as idle/okay.
    localparam logic [3:0] SLV_EN = 4'((1 << SLAVE_NUM) - 1);

    mux_state_e state_q;
    mux_state_e state_d;
    logic [SEL_W-1:0] sel_q;
    logic expire;
    logic unused_htrans;

    logic [DATA_WIDTH-1:0] rdata_arr [4];
    logic [3:0] ready_arr;
    logic [3:0] resp_arr;

    assign rdata_arr[0] = HRDATA_1;
    assign rdata_arr[1] = HRDATA_2;
    assign rdata_arr[2] = HRDATA_3;
    assign rdata_arr[3] = HRDATA_4;
    assign ready_arr = {HREADYOUT_4, HREADYOUT_3, HREADYOUT_2, HREADYOUT_1};
    assign resp_arr  = {HRESP_4, HRESP_3, HRESP_2, HRESP_1};
    assign unused_htrans = HTRANS[0];
    assign DATA_SEL = sel_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (HREADY) begin
                sel_q <= MUX_SEL;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DATA: begin
                if (expire) begin
                    state_d = ERR1;
                end else if (HREADY) begin
                    state_d = HTRANS[1] ? DATA : IDLE;
                end
            end
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
            ERR1: state_d = ERR2;
            ERR2: state_d = HTRANS[1] ? DATA : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        unique case (state_q)
            DATA: begin
                if (SLV_EN[sel_q]) begin
                    HRDATA = rdata_arr[sel_q];
                    HREADY = ready_arr[sel_q];
                    HRESP  = resp_arr[sel_q];
                end
            end
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
            ERR1: begin
                HREADY = 1'b0;
                HRESP  = HRESP_ERROR;
            end
            ERR2: HRESP = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
    ahb_wait_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .stall (state_q == DATA && !HREADY),
        .expire(expire)
    );
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Scoreboard bench for ahb_slave_mux: stimulus pushes per-cycle expectations,
// a monitor pops and compares on the falling edge (or an async probe).
module tb_ahb_slave_mux;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  MUX_SEL;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA_1, HRDATA_2, HRDATA_3, HRDATA_4;
    logic        HREADYOUT_1, HREADYOUT_2, HREADYOUT_3, HREADYOUT_4;
    logic        HRESP_1, HRESP_2, HRESP_3, HRESP_4;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [1:0]  DATA_SEL;

    ahb_slave_mux #(
        .SLAVE_NUM(4),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .MUX_SEL(MUX_SEL), .HTRANS(HTRANS),
        .HRDATA_1(HRDATA_1), .HRDATA_2(HRDATA_2),
        .HRDATA_3(HRDATA_3), .HRDATA_4(HRDATA_4),
        .HREADYOUT_1(HREADYOUT_1), .HREADYOUT_2(HREADYOUT_2),
        .HREADYOUT_3(HREADYOUT_3), .HREADYOUT_4(HREADYOUT_4),
        .HRESP_1(HRESP_1), .HRESP_2(HRESP_2),
        .HRESP_3(HRESP_3), .HRESP_4(HRESP_4),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .DATA_SEL(DATA_SEL)
    );

    typedef struct {
        logic [63:0] name;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic [1:0]  sel;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    event probe;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always begin
        @(negedge HCLK or probe);
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (HREADY !== e.rdy || HRESP !== e.rsp ||
                HRDATA !== e.data || DATA_SEL !== e.sel) begin
                errors++;
                $display("FAIL %0s: got rdy=%b rsp=%b data=%h sel=%0d want rdy=%b rsp=%b data=%h sel=%0d",
                         e.name, HREADY, HRESP, HRDATA, DATA_SEL,
                         e.rdy, e.rsp, e.data, e.sel);
            end
        end
    end

    task automatic push(input logic [63:0] nm, input logic r, input logic s,
                        input logic [31:0] d, input logic [1:0] sl);
        exp_t x;
        x.name = nm;
        x.rdy  = r;
        x.rsp  = s;
        x.data = d;
        x.sel  = sl;
        q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        HTRANS  = 2'd0;
        MUX_SEL = 2'd0;
        HRDATA_1 = 32'h1; HRDATA_2 = 32'h2; HRDATA_3 = 32'h3; HRDATA_4 = 32'h4;
        HREADYOUT_1 = 1'b1; HREADYOUT_2 = 1'b1;
        HREADYOUT_3 = 1'b1; HREADYOUT_4 = 1'b1;
        HRESP_1 = 1'b0; HRESP_2 = 1'b0; HRESP_3 = 1'b0; HRESP_4 = 1'b0;

        cyc(); push("rst", 1, 0, 0, 0);
        cyc(); HRESETn = 1'b1; push("idle0", 1, 0, 0, 0);

        // basic read from slave 3
        cyc(); HTRANS = 2'd2; MUX_SEL = 2'd2; push("rd_a", 1, 0, 0, 0);
        cyc(); HTRANS = 2'd0; MUX_SEL = 2'd0; HRDATA_3 = 32'hDEADBEEF;
        push("rd_d", 1, 0, 32'hDEADBEEF, 2);

        // three wait states with MUX_SEL toggling
        cyc(); HTRANS = 2'd2; MUX_SEL = 2'd0; HRDATA_1 = 32'h11111111;
        push("wt_a", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); HTRANS = 2'd0; MUX_SEL = i[0] ? 2'd1 : 2'd3;
            HREADYOUT_1 = 1'b0;
            push("wt_s", 0, 0, 32'h11111111, 0);
        end
        cyc(); HREADYOUT_1 = 1'b1; HRDATA_1 = 32'hCAFEF00D; MUX_SEL = 2'd3;
        push("wt_d", 1, 0, 32'hCAFEF00D, 0);

        // idle transfer ignores slave signals
        cyc(); HTRANS = 2'd0; MUX_SEL = 2'd1; push("idl_a", 1, 0, 0, 3);
        cyc(); MUX_SEL = 2'd0; HREADYOUT_2 = 1'b0; HRDATA_2 = 32'h1234;
        push("idl_d", 1, 0, 0, 1);

        // two-cycle error from slave 4, then SEQ to slave 1
        cyc(); HREADYOUT_2 = 1'b1; HTRANS = 2'd2; MUX_SEL = 2'd3;
        push("er_a", 1, 0, 0, 0);
        cyc(); HTRANS = 2'd3; MUX_SEL = 2'd0;
        HREADYOUT_4 = 1'b0; HRESP_4 = 1'b1; HRDATA_4 = 32'h0;
        push("er_1", 0, 1, 0, 3);
        cyc(); HREADYOUT_4 = 1'b1; push("er_2", 1, 1, 0, 3);
        cyc(); HRESP_4 = 1'b0; HTRANS = 2'd0; HRDATA_1 = 32'hA5A5A5A5;
        push("b2b", 1, 0, 32'hA5A5A5A5, 0);

        // slave 4 stalls
        cyc(); HTRANS = 2'd2; MUX_SEL = 2'd3; push("to_a", 1, 0, 0, 0);
        cyc(); HTRANS = 2'd0; MUX_SEL = 2'd0;
        HREADYOUT_4 = 1'b0; HRDATA_4 = 32'h44444444;
        push("to_s", 0, 0, 32'h44444444, 3);
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            cyc(); push("to_s", 0, 0, 32'h44444444, 3);
        end
        cyc(); push("to_e1", 0, 1, 0, 3);
        cyc(); push("to_e2", 1, 1, 0, 3);
        cyc(); HREADYOUT_4 = 1'b1; push("to_end", 1, 0, 0, 0);
`else
        for (int i = 1; i < 100; i++) begin
            cyc(); push("st_s", 0, 0, 32'h44444444, 3);
        end
        cyc(); HREADYOUT_4 = 1'b1; push("st_end", 1, 0, 32'h44444444, 3);
        cyc(); push("st_idle", 1, 0, 0, 0);
`endif

        // reset asserted mid data phase
        cyc(); HTRANS = 2'd2; MUX_SEL = 2'd1; push("rm_a", 1, 0, 0, 0);
        cyc(); HTRANS = 2'd0;
        HREADYOUT_1 = 1'b0; HREADYOUT_2 = 1'b0;
        HREADYOUT_3 = 1'b0; HREADYOUT_4 = 1'b0;
        HRDATA_1 = '1; HRDATA_2 = '1; HRDATA_3 = '1; HRDATA_4 = '1;
        push("rm_s", 0, 0, 32'hFFFFFFFF, 1);
        @(negedge HCLK);
        #1 HRESETn = 1'b0;
        #1 push("rm_rst", 1, 0, 0, 0);
        -> probe;
        cyc(); push("rm_hold", 1, 0, 0, 0);
        cyc(); HRESETn = 1'b1;
        HREADYOUT_1 = 1'b1; HREADYOUT_2 = 1'b1;
        HREADYOUT_3 = 1'b1; HREADYOUT_4 = 1'b1;
        push("rm_rel", 1, 0, 0, 0);

        repeat (3) cyc();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
